// File: rtl/jk_bank_controller.sv
// ---------------------------------------------------------------------------
// jk_bank_controller
//   Command sequencer for a bank of WIDTH external posedge JK flip-flops.
//   One command is accepted at a time over cmd_valid/cmd_ready. The block
//   drives J/K for exactly one bank clock edge per step, waits SETTLE_CYCLES
//   idle cycles, reads the bank back and reports the result with an error
//   flag that marks a read-back mismatch or an illegal opcode.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  high when a command can be accepted (IDLE)
//   cmd_op     0 HOLD, 1 CLEAR, 2 SET, 3 TOGGLE, 4 COUNT, 5-7 illegal
//   cmd_mask   bits affected by CLEAR/SET/TOGGLE
//   cmd_count  number of increments for COUNT
//   j_out      J inputs to the bank (nonzero only in DRIVE)
//   k_out      K inputs to the bank (nonzero only in DRIVE)
//   q_in       Q outputs from the bank
//   busy       high in any state other than IDLE
//   done       one-cycle completion pulse
//   result     bank Q captured at check, held until the next completion
//   error      mismatch or illegal op, held until the next completion
// ---------------------------------------------------------------------------
module jk_bank_controller #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [7:0]       cmd_count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_COUNT  = 3'd4;

    // SETTLE is entered with this value and exits once it has counted to 0.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [7:0]       iter_q;      // COUNT drive steps still to issue
    logic [3:0]       settle_q;
    logic [WIDTH-1:0] expected_q;  // bank value the command should produce

    logic             accept;
    logic [WIDTH-1:0] accept_expected;
    logic [16:0]      count_sum;

    // Toggle terms of a synchronous binary up-counter: bit i flips when all
    // lower bits are 1.
    function automatic logic [WIDTH-1:0] count_terms(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] t;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] drive_j(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] mask,
                                                 input logic [WIDTH-1:0] q);
        case (op)
            OP_SET, OP_TOGGLE: return mask;
            OP_COUNT:          return count_terms(q);
            default:           return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] drive_k(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] mask,
                                                 input logic [WIDTH-1:0] q);
        case (op)
            OP_CLEAR, OP_TOGGLE: return mask;
            OP_COUNT:            return count_terms(q);
            default:             return '0;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = cmd_valid && (state == IDLE);

    // Expected bank value, computed from q_in at the accept edge so the
    // snapshot never needs its own register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_sum       = 17'(q_in) + 17'(cmd_count);
        accept_expected = q_in;
        case (cmd_op)
            OP_CLEAR:  accept_expected = q_in & ~cmd_mask;
            OP_SET:    accept_expected = q_in | cmd_mask;
            OP_TOGGLE: accept_expected = q_in ^ cmd_mask;
            OP_COUNT:  accept_expected = count_sum[WIDTH-1:0];
            default:   accept_expected = q_in;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears j/k immediately, which
    // aborts any drive in progress without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_HOLD;
            mask_q     <= '0;
            iter_q     <= '0;
            settle_q   <= '0;
            expected_q <= '0;
            j_out      <= '0;
            k_out      <= '0;
            result     <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    j_out <= '0;
                    k_out <= '0;
                    if (accept) begin
                        op_q       <= cmd_op;
                        mask_q     <= cmd_mask;
                        expected_q <= accept_expected;
                        iter_q     <= (cmd_op == OP_COUNT) ? cmd_count : 8'd0;
                        if ((cmd_op == OP_CLEAR) || (cmd_op == OP_SET) ||
                            (cmd_op == OP_TOGGLE) ||
                            ((cmd_op == OP_COUNT) && (cmd_count != 8'd0))) begin
                            state <= DRIVE;
                            j_out <= drive_j(cmd_op, cmd_mask, q_in);
                            k_out <= drive_k(cmd_op, cmd_mask, q_in);
                        end else begin
                            // HOLD, zero-length COUNT and illegal ops finish
                            // immediately with the bank value seen at accept.
                            state  <= DONE;
                            result <= q_in;
                            error  <= (cmd_op > OP_COUNT);
                        end
                    end
                end

                DRIVE: begin
                    // The bank samples J/K on this edge; drop them right after.
                    j_out    <= '0;
                    k_out    <= '0;
                    settle_q <= SETTLE_LAST;
                    if (iter_q != 8'd0) begin
                        iter_q <= iter_q - 8'd1;
                    end
                    state <= SETTLE;
                end

                SETTLE: begin
                    if (settle_q != 4'd0) begin
                        settle_q <= settle_q - 4'd1;
                    end else if ((op_q == OP_COUNT) && (iter_q != 8'd0)) begin
                        // Next count step uses the settled live bank value.
                        state <= DRIVE;
                        j_out <= drive_j(op_q, mask_q, q_in);
                        k_out <= drive_k(op_q, mask_q, q_in);
                    end else begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    result <= q_in;
                    error  <= (q_in != expected_q);
                    state  <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    j_out <= '0;
                    k_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_controller.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_controller
//   Drives directed commands into jk_bank_controller with a behavioural JK
//   bank attached. Each issued command pushes its hand-computed result,
//   error flag and accept-to-done latency into a scoreboard queue; a
//   monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_jk_bank_controller;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_mask;
    logic [7:0]   cmd_count;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic [W-1:0] q_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         error;

    jk_bank_controller #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK bank; stuck bits are forced to 0 in the stored state.
    logic [W-1:0] bank_q = 4'hB;
    logic [W-1:0] stuck  = '0;
    always @(posedge clk) begin
        bank_q <= ((j_out & ~bank_q) | (~k_out & bank_q)) & ~stuck;
    end
    assign q_in = bank_q;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];

    // Drive-activity watcher: counts cycles in which J or K is nonzero.
    int           drive_cycles = 0;
    logic [W-1:0] last_j = '0;
    logic [W-1:0] last_k = '0;
    always @(negedge clk) begin
        if ((j_out | k_out) != '0) begin
            drive_cycles++;
            last_j = j_out;
            last_k = k_out;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",  32'(result), 32'(e.res));
                check("error",   32'(error),  32'(e.err));
                check("latency", 32'(cycle_cnt - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] mask,
                         input logic [7:0] cnt, input logic [W-1:0] exp_res,
                         input logic exp_err, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        drive_cycles = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_count = cnt;
        sb.push_back('{res: exp_res, err: exp_err, lat: lat, acc: cycle_cnt + 1});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) break;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [W-1:0] exp_tog;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_mask  = '0;
        cmd_count = '0;

        #7;
        check("rst_ready",  32'(cmd_ready), 32'd1);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_result", 32'(result),    32'd0);
        check("rst_error",  32'(error),     32'd0);
        check("rst_jk",     32'({j_out, k_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // CLEAR all from 4'hB -> 0; one drive cycle with j=0, k=F.
        issue(3'd1, 4'hF, 8'd0, 4'h0, 1'b0, 4);
        wait_empty();
        check("clear_drive_cycles", 32'(drive_cycles), 32'd1);
        check("clear_j", 32'(last_j), 32'h0);
        check("clear_k", 32'(last_k), 32'hF);

        // SET 0101, busy/ready while in flight.
        issue(3'd2, 4'b0101, 8'd0, 4'b0101, 1'b0, 4);
        check("busy_ready_low", 32'(cmd_ready), 32'd0);
        check("busy_high",      32'(busy),      32'd1);
        wait_empty();

        // TOGGLE 0011 -> 0110, then TOGGLE 1011 -> 1101.
        issue(3'd3, 4'b0011, 8'd0, 4'b0110, 1'b0, 4);
        wait_empty();
        issue(3'd3, 4'b1011, 8'd0, 4'hD, 1'b0, 4);
        wait_empty();

        // COUNT 5 from D: E,F,0,1,2 (wraps through F).
        issue(3'd4, 4'h0, 8'd5, 4'h2, 1'b0, 12);
        wait_empty();
        check("count_drive_cycles", 32'(drive_cycles), 32'd5);

        // Reach 9: CLEAR 0010 -> 0, SET 1001 -> 9.
        issue(3'd1, 4'b0010, 8'd0, 4'h0, 1'b0, 4);
        wait_empty();
        issue(3'd2, 4'h9, 8'd0, 4'h9, 1'b0, 4);
        wait_empty();

        // HOLD, COUNT 0, illegal op 6: immediate completion, no drive.
        drive_cycles = 0;
        issue(3'd0, 4'hF, 8'd0, 4'h9, 1'b0, 1);
        issue(3'd4, 4'hF, 8'd0, 4'h9, 1'b0, 1);
        issue(3'd6, 4'hF, 8'd3, 4'h9, 1'b1, 1);
        wait_empty();
        check("nodrive_cycles", 32'(drive_cycles), 32'd0);

        // Stuck-at-0 on bit 2: SET 4 from 0 reads back 0 -> error.
        issue(3'd1, 4'hF, 8'd0, 4'h0, 1'b0, 4);
        wait_empty();
        stuck = 4'h4;
        issue(3'd2, 4'h4, 8'd0, 4'h0, 1'b1, 4);
        wait_empty();
        stuck = 4'h0;

        // mask=0 TOGGLE still walks DRIVE; bank unchanged.
        issue(3'd3, 4'h0, 8'd0, 4'h0, 1'b0, 4);
        wait_empty();

        // COUNT 18 from 0 wraps past 2^W: 18 mod 16 = 2.
        issue(3'd4, 4'h0, 8'd18, 4'h2, 1'b0, 38);
        wait_empty();

        // Reset during COUNT 10 while the third drive is on the wires.
        issue(3'd4, 4'h0, 8'd10, 4'hC, 1'b0, 22);
        n = 0;
        while (drive_cycles < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_count_reached", 32'(drive_cycles), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_j",     32'(j_out), 32'd0);
        check("abort_k",     32'(k_out), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);  // monitor flags any stray done
        check("abort_bank_partial", 32'(bank_q), 32'h4);

        exp_tog = bank_q ^ 4'hF;
        issue(3'd3, 4'hF, 8'd0, exp_tog, 1'b0, 4);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
